// File: rtl/la_seq.sv
// Pattern sequencer for the LA path: replays a small pattern memory toward one LA bank at a programmed step interval.
// Optional build macro LA_SEQ_CAPTURE_EN adds a read-only capture memory sampled from la_data_in on every step.
module la_seq #(
    parameter logic [31:0] BASE_ADR = 32'h2300_0000,
    parameter int          DEPTH    = 16,
    parameter int          DIV_W    = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [31:0]  iomem_addr,
    input  logic         iomem_valid,
    input  logic [3:0]   iomem_wstrb,
    input  logic [31:0]  iomem_wdata,
    output logic [31:0]  iomem_rdata,
    output logic         iomem_ready,
    input  logic [127:0] la_data_in,
    output logic [31:0]  seq_data,
    output logic [1:0]   seq_bank,
    output logic         seq_valid,
    output logic         seq_active
);
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [5:0] LEN_MAX = 6'(DEPTH - 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_d;

    logic [31:0]      mem [DEPTH];
    logic             loop_q, done_q, first_q, ending_q;
    logic [1:0]       bank_q;
    logic [DIV_W-1:0] div_q, cnt_q;
    logic [5:0]       len_q, len_wr;
    logic [15:0]      steps_q;
    logic [AW-1:0]    idx_q, step_idx, mem_idx;
    logic [7:0]       off;
    logic [31:0]      wmask, div_merge, rd_val;
    logic             access, wr, go, pulse, start_wr, stop_wr, w1c_done;
    logic             ctrl_sel, div_sel, len_sel, stat_sel, mem_sel;
    logic             unused;

    assign off       = iomem_addr[7:0];
    assign access    = iomem_valid && (iomem_addr[31:8] == BASE_ADR[31:8]) && !iomem_ready;
    assign wr        = access && (iomem_wstrb != 4'b0000);
    assign wmask     = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign div_merge = (32'(div_q) & ~wmask) | (iomem_wdata & wmask);
    assign len_wr    = (iomem_wdata[5:0] > LEN_MAX) ? LEN_MAX : iomem_wdata[5:0];

    assign ctrl_sel = (off == 8'h00);
    assign div_sel  = (off == 8'h04);
    assign len_sel  = (off == 8'h08);
    assign stat_sel = (off == 8'h0C);
    assign mem_sel  = (off[7:6] == 2'b01) && ({4'b0, off[5:2]} < 8'(DEPTH));
    assign mem_idx  = AW'(off[5:2]);

    assign start_wr = wr && ctrl_sel && iomem_wstrb[0] && iomem_wdata[0];
    assign stop_wr  = wr && ctrl_sel && iomem_wstrb[0] && iomem_wdata[1];
    assign w1c_done = wr && stat_sel && iomem_wstrb[0] && iomem_wdata[0];

    assign seq_active = (state == RUN);

`ifdef LA_SEQ_CAPTURE_EN
    logic [31:0]   cap [DEPTH];
    logic          cap_sel;
    logic [AW-1:0] cap_idx;

    assign cap_sel = off[7] && ({3'b0, off[6:2]} < 8'(DEPTH));
    assign cap_idx = AW'(off[6:2]);
    assign unused  = ^off[1:0];

    // idx_q and seq_bank still describe the step being presented while seq_valid is high.
    always_ff @(posedge clk) begin
        if (seq_valid) cap[idx_q] <= la_data_in[{seq_bank, 5'b0} +: 32];
    end
`else
    assign unused = ^{la_data_in, off[1:0]};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_d;
    end

    // STOP beats everything; the tail state after a one-shot's last word is a single cycle.
    always_comb begin
        state_d  = state;
        go       = 1'b0;
        pulse    = 1'b0;
        step_idx = idx_q;
        case (state)
            IDLE: begin
                if (start_wr && !stop_wr) begin
                    state_d = RUN;
                    go      = 1'b1;
                end
            end
            RUN: begin
                if (stop_wr || ending_q) begin
                    state_d = IDLE;
                end else if (first_q) begin
                    pulse    = 1'b1;
                    step_idx = '0;
                end else if (cnt_q == div_q) begin
                    pulse    = 1'b1;
                    step_idx = (6'(idx_q) == len_q) ? '0 : idx_q + AW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            loop_q      <= 1'b0;
            bank_q      <= 2'b0;
            div_q       <= '0;
            len_q       <= '0;
            done_q      <= 1'b0;
            steps_q     <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            ending_q    <= 1'b0;
            seq_data    <= '0;
            seq_bank    <= 2'b0;
            seq_valid   <= 1'b0;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else begin
            iomem_ready <= access;
            if (access) iomem_rdata <= rd_val;

            if (wr && ctrl_sel && iomem_wstrb[0]) begin
                loop_q <= iomem_wdata[2];
                bank_q <= iomem_wdata[5:4];
            end
            if (wr && div_sel && state == IDLE) div_q <= DIV_W'(div_merge);
            if (wr && len_sel && iomem_wstrb[0] && state == IDLE) len_q <= len_wr;
            if (w1c_done) done_q <= 1'b0;

            seq_valid <= pulse;
            if (go) begin
                idx_q    <= '0;
                cnt_q    <= '0;
                steps_q  <= '0;
                done_q   <= 1'b0;
                first_q  <= 1'b1;
                ending_q <= 1'b0;
            end else if (pulse) begin
                idx_q    <= step_idx;
                cnt_q    <= '0;
                first_q  <= 1'b0;
                seq_data <= mem[step_idx];
                seq_bank <= bank_q;
                steps_q  <= steps_q + 16'd1;
                ending_q <= (6'(step_idx) == len_q) && !loop_q;
            end else if (state == RUN) begin
                if (stop_wr) begin
                    ending_q <= 1'b0;
                end else if (ending_q) begin
                    done_q   <= 1'b1;
                    ending_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + DIV_W'(1);
                end
            end
        end
    end

    // Pattern words have no reset; a write racing a step of the same index lands on the following step.
    always_ff @(posedge clk) begin
        if (wr && mem_sel) begin
            for (int b = 0; b < 4; b++) begin
                if (iomem_wstrb[b]) mem[mem_idx][8*b +: 8] <= iomem_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (ctrl_sel)      rd_val = {23'b0, seq_active, 2'b0, bank_q, 1'b0, loop_q, 2'b0};
        else if (div_sel)  rd_val = 32'(div_q);
        else if (len_sel)  rd_val = {26'b0, len_q};
        else if (stat_sel) rd_val = {8'b0, steps_q, 7'b0, done_q};
        else if (mem_sel)  rd_val = mem[mem_idx];
`ifdef LA_SEQ_CAPTURE_EN
        else if (cap_sel)  rd_val = cap[cap_idx];
`endif
    end
endmodule

// File: tb/tb_la_seq.sv
// Bench for la_seq: random pattern runs predicted from the register-level rules, checked through
// expected queues that monitors drain whenever the DUT acknowledges an access or strobes seq_valid.
`timescale 1ns/1ps
module tb_la_seq;
    localparam logic [31:0] BASE = 32'h2300_0000;
    localparam logic [7:0]  CTRL = 8'h00, DIV = 8'h04, LEN = 8'h08, STAT = 8'h0C;

    logic         clk = 1'b0;
    logic         resetn;
    logic [31:0]  iomem_addr, iomem_wdata, iomem_rdata;
    logic         iomem_valid, iomem_ready;
    logic [3:0]   iomem_wstrb;
    logic [127:0] la_data_in;
    logic [31:0]  seq_data;
    logic [1:0]   seq_bank;
    logic         seq_valid, seq_active;

    la_seq dut (
        .clk(clk), .resetn(resetn),
        .iomem_addr(iomem_addr), .iomem_valid(iomem_valid), .iomem_wstrb(iomem_wstrb),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata), .iomem_ready(iomem_ready),
        .la_data_in(la_data_in),
        .seq_data(seq_data), .seq_bank(seq_bank), .seq_valid(seq_valid), .seq_active(seq_active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] acc_q[$];   // {is_read, expected rdata}
    logic [65:0] exp_q[$];   // {cycle, bank, data}
    logic [31:0] m_mem[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [32:0] ea;
        logic [65:0] ep;
        if (resetn) begin
            if (iomem_ready) begin
                if (acc_q.size() == 0) check("unexpected_ready", 32'd1, 32'd0);
                else begin
                    ea = acc_q.pop_front();
                    if (ea[32]) check("rdata", iomem_rdata, ea[31:0]);
                end
            end
            if (seq_valid) begin
                if (exp_q.size() == 0) check("unexpected_seq_valid", 32'd1, 32'd0);
                else begin
                    ep = exp_q.pop_front();
                    check("seq_data", seq_data, ep[31:0]);
                    check("seq_bank", 32'(seq_bank), 32'(ep[33:32]));
                    check("seq_cycle", 32'(cyc), ep[65:34]);
                    check("seq_active_on_pulse", 32'(seq_active), 32'd1);
                end
            end
        end
    end

    // Called at a negedge; the ready cycle is expected one cycle later.
    task automatic bus(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                       input logic [31:0] exp, output int rc);
        int t0, k;
        t0 = cyc;
        acc_q.push_back({(wstrb == 4'b0000), exp});
        iomem_addr  = addr;
        iomem_wstrb = wstrb;
        iomem_wdata = wdata;
        iomem_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!iomem_ready && k < 8);
        check("ready_latency", 32'(cyc - t0), 32'd1);
        rc = cyc;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        @(negedge clk);
        check("ready_width", 32'(iomem_ready), 32'd0);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        int rc;
        bus(BASE + {24'b0, off}, 4'hF, d, 32'd0, rc);
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp);
        int rc;
        bus(BASE + {24'b0, off}, 4'h0, 32'd0, exp, rc);
    endtask

    // One-shot run over m_mem[0..len]: word k appears at ready+1+k*(div+1).
    task automatic run_oneshot(input int div, input int len, input logic [1:0] bank);
        int rc, last, k;
        for (int i = 0; i <= len; i++) wr(8'h40 + 8'(4 * i), m_mem[i]);
        wr(DIV, 32'(div));
        wr(LEN, 32'(len));
        wr(CTRL, {26'b0, bank, 4'b0});
        rc = cyc + 1;
        for (int i = 0; i <= len; i++) exp_q.push_back({32'(rc + 1 + i * (div + 1)), bank, m_mem[i]});
        wr(CTRL, {26'b0, bank, 4'b0001});
        last = rc + 1 + len * (div + 1);
        k = 0;
        while (cyc < last + 1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("active_after_last", 32'(seq_active), 32'd0);
        check("data_hold", seq_data, m_mem[len]);
        check("bank_hold", 32'(seq_bank), 32'(bank));
        rd(STAT, (32'(len + 1) << 8) | 32'd1);
        wr(STAT, 32'd1);
        rd(STAT, 32'(len + 1) << 8);
        rd(CTRL, {26'b0, bank, 4'b0});
    endtask

    // Looping run with ignored DIV/START writes, a bank change and a pattern write mid-run, then STOP.
    task automatic run_loop(input int div, input int len, input logic [1:0] ba, input logic [1:0] bb,
                            input logic [31:0] nw, input int w);
        int rc0, w_ctrl, w_mem, stop_c, n, c;
        logic [1:0] b;
        logic [31:0] d;
        for (int i = 0; i <= len; i++) begin
            m_mem[i] = $urandom;
            wr(8'h40 + 8'(4 * i), m_mem[i]);
        end
        wr(DIV, 32'(div));
        wr(LEN, 32'(len));
        rc0    = cyc + 1;
        w_ctrl = rc0 + 4;
        w_mem  = rc0 + 6;
        stop_c = rc0 + 8 + w;
        n = 0;
        c = rc0 + 1;
        while (c < stop_c) begin
            b = (c > w_ctrl) ? bb : ba;
            d = ((n % (len + 1)) == 1 && c > w_mem) ? nw : m_mem[n % (len + 1)];
            exp_q.push_back({32'(c), b, d});
            n++;
            c += div + 1;
        end
        wr(CTRL, {26'b0, ba, 4'b0101});
        wr(DIV, 32'd9);
        wr(CTRL, {26'b0, bb, 4'b0101});
        wr(8'h44, nw);
        m_mem[1] = nw;
        repeat (w) @(negedge clk);
        wr(CTRL, {26'b0, bb, 4'b0110});
        check("active_after_stop", 32'(seq_active), 32'd0);
        repeat (4) @(negedge clk);
        rd(STAT, 32'(n) << 8);
        rd(DIV, 32'(div));
        rd(CTRL, {26'b0, bb, 4'b0100});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int rc, x, k;
        logic saw;
        resetn      = 1'b0;
        iomem_addr  = '0;
        iomem_valid = 1'b0;
        iomem_wstrb = '0;
        iomem_wdata = '0;
        la_data_in  = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(iomem_ready), 32'd0);
        check("rst_rdata", iomem_rdata, 32'd0);
        check("rst_seq_data", seq_data, 32'd0);
        check("rst_seq_bank", 32'(seq_bank), 32'd0);
        check("rst_seq_valid", 32'(seq_valid), 32'd0);
        check("rst_seq_active", 32'(seq_active), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        rd(CTRL, 32'd0);
        rd(DIV, 32'd0);
        rd(LEN, 32'd0);
        rd(STAT, 32'd0);

        wr(DIV, 32'd5);
        wr(LEN, 32'd3);
        wr(CTRL, 32'h20);
        rd(DIV, 32'h5);
        rd(LEN, 32'h3);
        rd(CTRL, 32'h20);
        bus(BASE + 32'h04, 4'b0010, 32'hFFFF_FF12, 32'd0, rc);
        rd(DIV, 32'h0000_FF05);
        wr(DIV, 32'd5);
        wr(LEN, 32'h3F);
        rd(LEN, 32'd15);
        wr(8'h20, 32'hFFFF_FFFF);
        rd(8'h20, 32'd0);
        rd(DIV, 32'd5);

        iomem_addr  = 32'h2400_0000;
        iomem_wstrb = 4'h0;
        iomem_valid = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (iomem_ready) saw = 1'b1;
        end
        iomem_valid = 1'b0;
        check("bad_base_no_ready", 32'(saw), 32'd0);

        m_mem[0] = 32'h11; m_mem[1] = 32'h22; m_mem[2] = 32'h33; m_mem[3] = 32'h44;
        for (int i = 0; i < 4; i++) wr(8'h40 + 8'(4 * i), m_mem[i]);
        rd(8'h48, 32'h33);
        run_oneshot(2, 3, 2'd2);

        for (int it = 0; it < 6; it++) begin
            int dv, ln;
            dv = (it == 0) ? 0 : $urandom_range(0, 4);
            ln = (it == 0) ? 0 : $urandom_range(0, 5);
            for (int i = 0; i <= ln; i++) m_mem[i] = $urandom;
            run_oneshot(dv, ln, 2'($urandom_range(0, 3)));
        end

        run_loop(0, 1, 2'd1, 2'd3, 32'h0000_00AA, 6);
        run_loop($urandom_range(0, 3), $urandom_range(1, 3), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), $urandom, $urandom_range(3, 12));

        wr(CTRL, 32'h03);
        repeat (4) @(negedge clk);
        check("start_stop_same_write", 32'(seq_active), 32'd0);

`ifdef LA_SEQ_CAPTURE_EN
        m_mem[0] = $urandom;
        m_mem[1] = $urandom;
        run_oneshot(1, 1, 2'd1);
        rd(8'h80, la_data_in[63:32]);
        rd(8'h84, la_data_in[63:32]);
`else
        rd(8'h80, 32'd0);
`endif

        for (int i = 0; i < 4; i++) begin
            m_mem[i] = $urandom;
            wr(8'h40 + 8'(4 * i), m_mem[i]);
        end
        wr(DIV, 32'd1);
        wr(LEN, 32'd3);
        rc = cyc + 1;
        x  = rc + 8;
        k  = 0;
        for (int c = rc + 1; c <= x; c += 2) begin
            exp_q.push_back({32'(c), 2'd3, m_mem[k % 4]});
            k++;
        end
        wr(CTRL, 32'h35);
        repeat (7) @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        check("midrun_rst_active", 32'(seq_active), 32'd0);
        check("midrun_rst_valid", 32'(seq_valid), 32'd0);
        check("midrun_rst_data", seq_data, 32'd0);
        check("midrun_rst_bank", 32'(seq_bank), 32'd0);
        check("midrun_rst_rdata", iomem_rdata, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        rd(CTRL, 32'd0);
        rd(LEN, 32'd0);
        rd(STAT, 32'd0);
        repeat (4) @(negedge clk);

        check("pulse_queue_empty", 32'(exp_q.size()), 32'd0);
        check("access_queue_empty", 32'(acc_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
